// File: rtl/sym_gen.sv
// Paced pseudo-random 7-segment symbol generator: one LFSR-chosen symbol every symGenMax cycles.
// Optional build macro SYMGEN_SPECIAL_DP_EN lights the decimal point on letter symbols (A-F).
module sym_gen #(
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic        Clk100M,
    input  logic        Rst,
    input  logic [31:0] symGenMax,
    input  logic        genSym,
    output logic        generated,
    output logic        special,
    output logic [7:0]  generatedSym
);

    // An all-zero LFSR would lock up, so a zero seed is replaced.
    localparam logic [15:0] SEED_EFF = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;

    function automatic logic [7:0] seg_lookup(input logic [3:0] idx);
        logic [7:0] pat;
        case (idx)
            4'd0:    pat = 8'h03;
            4'd1:    pat = 8'h9F;
            4'd2:    pat = 8'h25;
            4'd3:    pat = 8'h0D;
            4'd4:    pat = 8'h99;
            4'd5:    pat = 8'h49;
            4'd6:    pat = 8'h41;
            4'd7:    pat = 8'h1F;
            4'd8:    pat = 8'h01;
            4'd9:    pat = 8'h09;
            4'd10:   pat = 8'h11;
            4'd11:   pat = 8'hC1;
            4'd12:   pat = 8'h63;
            4'd13:   pat = 8'h85;
            4'd14:   pat = 8'h61;
            4'd15:   pat = 8'h71;
            default: pat = 8'hFF;
        endcase
        return pat;
    endfunction

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

    logic [31:0] counter_r;
    logic [31:0] counter_s;
    logic [15:0] lfsr_r;
    logic [15:0] lfsr_s;
    logic        generated_r;
    logic        generated_s;
    logic        special_r;
    logic        special_s;
    logic [7:0]  sym_r;
    logic [7:0]  sym_s;
    logic [31:0] threshold_s;
    logic        event_s;
    logic [3:0]  idx_s;
    logic [7:0]  pattern_s;

    // Period threshold and event detection; periods of 0 and 1 both mean "every cycle".
    always_comb begin
        threshold_s = 32'd0;
        if (symGenMax <= 32'd1) begin
            threshold_s = 32'd0;
        end else begin
            threshold_s = symGenMax - 32'd1;
        end
        event_s = genSym && (counter_r >= threshold_s);
    end

    // Symbol pattern for the current LFSR nibble, with optional decimal point on letters.
    always_comb begin
        idx_s     = lfsr_r[3:0];
        pattern_s = seg_lookup(idx_s);
`ifdef SYMGEN_SPECIAL_DP_EN
        if (idx_s >= 4'd10) begin
            pattern_s[0] = 1'b0;
        end else begin
            pattern_s[0] = 1'b1;
        end
`endif
    end

    // Next-state logic: counter pacing, and symbol/LFSR update on events only.
    always_comb begin
        counter_s   = counter_r;
        lfsr_s      = lfsr_r;
        generated_s = 1'b0;
        special_s   = special_r;
        sym_s       = sym_r;
        if (!genSym) begin
            counter_s = 32'd0;
        end else if (event_s) begin
            counter_s   = 32'd0;
            generated_s = 1'b1;
            sym_s       = pattern_s;
            special_s   = (idx_s >= 4'd10);
            lfsr_s      = lfsr_step(lfsr_r);
        end else begin
            counter_s = counter_r + 32'd1;
        end
    end

    // State and output registers.
    always_ff @(posedge Clk100M or posedge Rst) begin
        if (Rst) begin
            counter_r   <= 32'd0;
            lfsr_r      <= SEED_EFF;
            generated_r <= 1'b0;
            special_r   <= 1'b0;
            sym_r       <= 8'h01;
        end else begin
            counter_r   <= counter_s;
            lfsr_r      <= lfsr_s;
            generated_r <= generated_s;
            special_r   <= special_s;
            sym_r       <= sym_s;
        end
    end

    assign generated    = generated_r;
    assign special      = special_r;
    assign generatedSym = sym_r;

endmodule

// File: tb/tb_sym_gen.sv
// Randomized self-checking bench for sym_gen against a cycle-level reference model.
// The model tracks enabled cycles since the last symbol and walks the LFSR with a tap mask.
module tb_sym_gen;

    logic        Clk100M = 1'b0;
    logic        Rst;
    logic [31:0] symGenMax;
    logic        genSym;
    logic        generated;
    logic        special;
    logic [7:0]  generatedSym;

    int total = 0;
    int bad   = 0;

    logic [7:0]  seg_tab [16] = '{8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F,
                                  8'h01, 8'h09, 8'h11, 8'hC1, 8'h63, 8'h85, 8'h61, 8'h71};

    logic [15:0] m_lfsr;
    int unsigned m_run;
    logic        m_gen;
    logic        m_spec;
    logic [7:0]  m_sym;

    int          step_no;
    int          pulse_at [$];
    logic [7:0]  pulse_sym [$];

    sym_gen dut (
        .Clk100M      (Clk100M),
        .Rst          (Rst),
        .symGenMax    (symGenMax),
        .genSym       (genSym),
        .generated    (generated),
        .special      (special),
        .generatedSym (generatedSym)
    );

    always #5 Clk100M = ~Clk100M;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        logic fb;
        fb = ^(s & 16'hB400);
        return (s << 1) | {15'd0, fb};
    endfunction

    task automatic model_reset();
        m_lfsr = 16'hACE1;
        m_run  = 0;
        m_gen  = 1'b0;
        m_spec = 1'b0;
        m_sym  = 8'h01;
    endtask

    // One clock: drive inputs, let the edge happen, advance the model, compare.
    task automatic step(input logic en, input logic [31:0] max);
        int unsigned period;
        int          idx;
        genSym    = en;
        symGenMax = max;
        @(posedge Clk100M);
        #1;
        step_no++;
        period = (max <= 32'd1) ? 1 : max;
        m_gen  = 1'b0;
        if (!en) begin
            m_run = 0;
        end else begin
            m_run++;
            if (m_run >= period) begin
                m_run  = 0;
                m_gen  = 1'b1;
                idx    = int'(m_lfsr % 16);
                m_sym  = seg_tab[idx];
`ifdef SYMGEN_SPECIAL_DP_EN
                if (idx >= 10) m_sym = m_sym & 8'hFE;
`endif
                m_spec = (idx >= 10);
                m_lfsr = lfsr_next(m_lfsr);
            end
        end
        check("generated", {31'd0, generated}, {31'd0, m_gen});
        check("special", {31'd0, special}, {31'd0, m_spec});
        check("symbol", {24'd0, generatedSym}, {24'd0, m_sym});
        if (generated) begin
            pulse_at.push_back(step_no);
            pulse_sym.push_back(generatedSym);
        end
    endtask

    task automatic do_reset();
        Rst = 1'b1;
        genSym = 1'b0;
        symGenMax = 32'd10;
        model_reset();
        repeat (2) @(posedge Clk100M);
        #1;
        check("rst_gen", {31'd0, generated}, 32'd0);
        check("rst_spec", {31'd0, special}, 32'd0);
        check("rst_sym", {24'd0, generatedSym}, 32'h01);
        @(negedge Clk100M);
        Rst = 1'b0;
        step_no = 0;
        pulse_at.delete();
        pulse_sym.delete();
    endtask

    initial begin
        int events;
        int cycles;
        int found;
        logic [7:0] base;

        // Idle after reset: no pulses, reset pattern held.
        do_reset();
        for (int i = 0; i < 50; i++) step(1'b0, 32'd10);
        check("idle_pulses", pulse_at.size(), 32'd0);

        // Period 10: pulses at 10, 20, 30 cycles after rise.
        do_reset();
        for (int i = 0; i < 30; i++) step(1'b1, 32'd10);
        check("p10_count", pulse_at.size(), 32'd3);
        if (pulse_at.size() == 3) begin
            check("p10_t0", pulse_at[0], 32'd10);
            check("p10_t1", pulse_at[1], 32'd20);
            check("p10_t2", pulse_at[2], 32'd30);
            check("p10_s0", {24'd0, pulse_sym[0]}, 32'h9F);
            check("p10_s1", {24'd0, pulse_sym[1]}, 32'h0D);
            check("p10_s2", {24'd0, pulse_sym[2]}, 32'h1F);
        end

        // Period 1: a pulse every cycle.
        do_reset();
        for (int i = 0; i < 8; i++) step(1'b1, 32'd1);
        check("p1_count", pulse_at.size(), 32'd8);
        if (pulse_at.size() >= 3) begin
            check("p1_s0", {24'd0, pulse_sym[0]}, 32'h9F);
            check("p1_s1", {24'd0, pulse_sym[1]}, 32'h0D);
            check("p1_s2", {24'd0, pulse_sym[2]}, 32'h1F);
        end

        // Drop enable mid-period, restart gets a full period and the next symbol.
        do_reset();
        for (int i = 0; i < 15; i++) step(1'b1, 32'd10);
        for (int i = 0; i < 7; i++) step(1'b0, 32'd10);
        pulse_at.delete();
        pulse_sym.delete();
        step_no = 0;
        for (int i = 0; i < 12; i++) step(1'b1, 32'd10);
        check("drop_count", pulse_at.size(), 32'd1);
        if (pulse_at.size() >= 1) begin
            check("drop_time", pulse_at[0], 32'd10);
            check("drop_sym", {24'd0, pulse_sym[0]}, 32'h0D);
        end

        // Asynchronous reset mid-period.
        for (int i = 0; i < 4; i++) step(1'b1, 32'd10);
        #2;
        Rst = 1'b1;
        #1;
        check("arst_gen", {31'd0, generated}, 32'd0);
        check("arst_spec", {31'd0, special}, 32'd0);
        check("arst_sym", {24'd0, generatedSym}, 32'h01);
        model_reset();
        @(negedge Clk100M);
        Rst = 1'b0;
        pulse_at.delete();
        pulse_sym.delete();
        step_no = 0;
        for (int i = 0; i < 10; i++) step(1'b1, 32'd10);
        check("arst_restart", pulse_sym.size(), 32'd1);
        if (pulse_sym.size() >= 1) check("arst_first", {24'd0, pulse_sym[0]}, 32'h9F);

        // Random enables and periods, including period drops below the running count.
        do_reset();
        events = 0;
        cycles = 0;
        while (events < 2000 && cycles < 40000) begin
            step(($urandom_range(0, 9) != 0) ? 1'b1 : 1'b0, 32'($urandom_range(0, 4)));
            cycles++;
            if (generated) begin
                events++;
`ifdef SYMGEN_SPECIAL_DP_EN
                base = generatedSym | 8'h01;
                check("dp_rule", {31'd0, generatedSym[0]}, {31'd0, ~special});
`else
                base = generatedSym;
`endif
                found = -1;
                for (int k = 0; k < 16; k++) if (seg_tab[k] == base) found = k;
                check("in_table", {31'd0, found >= 0}, 32'd1);
                check("spec_rule", {31'd0, special}, {31'd0, found >= 10});
            end
        end
        check("event_budget", {31'd0, events >= 2000}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
